// File: rtl/cpu_sequencer.sv
// MSP430 instruction sequencer: fetches and decodes each instruction word and
// steps one state per memory access while driving register-file and bus strobes.
module cpu_sequencer #(
  parameter logic [15:0] RST_VECTOR = 16'hFFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] MDB,
  input  logic [3:0]  SRflags,
  input  logic        GIE,
  input  logic        IRQ,
  input  logic        NMI,
  input  logic [15:0] VecAddr,
  output logic [15:0] IW,
  output logic        IF,
  output logic        IdxF,
  output logic        SPF,
  output logic        INTACK,
  output logic        Ex,
  output logic        srcInc,
  output logic        RW,
  output logic        MemRd,
  output logic        MemWr,
  output logic [2:0]  MabSel,
  output logic [1:0]  MdbSel,
  output logic [15:0] VecOut,
  output logic        Illegal,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    RST_VEC  = 4'd0,  FETCH   = 4'd1,  SRC_IDX = 4'd2,  SRC_RD  = 4'd3,
    DST_IDX  = 4'd4,  DST_RD  = 4'd5,  EXEC    = 4'd6,  DST_WR  = 4'd7,
    PUSH_DEC = 4'd8,  PUSH_WR = 4'd9,  INT_SP1 = 4'd10, INT_PC  = 4'd11,
    INT_SP2  = 4'd12, INT_SR  = 4'd13, INT_VEC = 4'd14
  } state_t;

  state_t state, next_state;

  // During FETCH the word is still on MDB; afterwards it lives in IW.
  logic       sel_mdb;
  logic [5:0] d_top;
  logic [2:0] d_op;
  logic [3:0] d_src, d_dst, opr;
  logic [1:0] d_as;
  logic       d_ad;
  logic       is_jump, is_fmt1, is_fmt2, is_push, is_illegal;
  logic       need_idx, need_rd, dst_mem, mem_write, reg_write, jump_taken, take_int;

  logic       raw_if, raw_idxf, raw_spf, raw_intack, raw_ex, raw_srcinc, raw_rw;
  logic       raw_memrd, raw_memwr, raw_illegal;
  logic [2:0] raw_mab;
  logic [1:0] raw_mdb;

  assign sel_mdb  = (state == FETCH);
  assign d_top    = sel_mdb ? MDB[15:10] : IW[15:10];
  assign d_op     = sel_mdb ? MDB[9:7]   : IW[9:7];
  assign d_src    = sel_mdb ? MDB[11:8]  : IW[11:8];
  assign d_ad     = sel_mdb ? MDB[7]     : IW[7];
  assign d_as     = sel_mdb ? MDB[5:4]   : IW[5:4];
  assign d_dst    = sel_mdb ? MDB[3:0]   : IW[3:0];
  assign take_int = NMI | (IRQ & GIE);

  // Instruction class and addressing-mode decode
  always_comb begin
    is_jump    = (d_top[5:3] == 3'b001);
    is_fmt1    = (d_top[5:2] >= 4'd4);
    is_fmt2    = (d_top == 6'b000100) && (d_op <= 3'd4);
    is_push    = (d_top == 6'b000100) && (d_op == 3'd4);
    is_illegal = !(is_jump || is_fmt1 || is_fmt2);
    opr        = is_fmt1 ? d_src : d_dst;
    need_idx   = (is_fmt1 || is_fmt2) && (d_as == 2'b01) && (opr != 4'd3);
    need_rd    = (is_fmt1 || is_fmt2) &&
                 ((d_as[1] && (opr != 4'd2) && (opr != 4'd3)) || need_idx);
    dst_mem    = is_fmt1 && d_ad;
    mem_write  = dst_mem || (is_fmt2 && !is_push && need_rd);
    if (is_fmt1) begin
      reg_write = !d_ad && (d_top[5:2] != 4'h9) && (d_top[5:2] != 4'hB);
    end else begin
      reg_write = is_fmt2 && !is_push && (d_as == 2'b00);
    end
  end

  // Jump condition against {V,N,Z,C}
  always_comb begin
    case (IW[12:10])
      3'd0:    jump_taken = !SRflags[1];
      3'd1:    jump_taken = SRflags[1];
      3'd2:    jump_taken = !SRflags[0];
      3'd3:    jump_taken = SRflags[0];
      3'd4:    jump_taken = SRflags[2];
      3'd5:    jump_taken = !(SRflags[2] ^ SRflags[3]);
      3'd6:    jump_taken = SRflags[2] ^ SRflags[3];
      default: jump_taken = 1'b1;
    endcase
  end

  // State register and latched instruction/vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RST_VEC;
      IW     <= 16'h0000;
      VecOut <= RST_VECTOR;
    end else begin
      state <= next_state;
      if (state == FETCH) begin
        IW <= MDB;
      end
      if ((next_state == INT_SP1) && (state != INT_SP1)) begin
        VecOut <= VecAddr;
      end
    end
  end

  // Next-state and raw strobe decode
  always_comb begin
    next_state  = state;
    raw_if      = 1'b0;
    raw_idxf    = 1'b0;
    raw_spf     = 1'b0;
    raw_intack  = 1'b0;
    raw_ex      = 1'b0;
    raw_srcinc  = 1'b0;
    raw_rw      = 1'b0;
    raw_memrd   = 1'b0;
    raw_memwr   = 1'b0;
    raw_illegal = 1'b0;
    raw_mab     = 3'd0;
    raw_mdb     = 2'd0;
    case (state)
      RST_VEC: begin
        raw_memrd = 1'b1; raw_intack = 1'b1; raw_mab = 3'd4; next_state = FETCH;
      end
      FETCH: begin
        raw_if = 1'b1; raw_memrd = 1'b1;
        if (is_illegal) begin
          raw_illegal = 1'b1; next_state = FETCH;
        end else if (need_idx) begin
          next_state = SRC_IDX;
        end else if (need_rd) begin
          next_state = SRC_RD;
        end else if (dst_mem) begin
          next_state = DST_IDX;
        end else begin
          next_state = EXEC;
        end
      end
      SRC_IDX: begin
        raw_idxf = 1'b1; raw_memrd = 1'b1; next_state = SRC_RD;
      end
      SRC_RD: begin
        raw_memrd = 1'b1; raw_mab = 3'd1; raw_srcinc = (IW[5:4] == 2'b11);
        next_state = dst_mem ? DST_IDX : EXEC;
      end
      DST_IDX: begin
        raw_idxf = 1'b1; raw_memrd = 1'b1; next_state = DST_RD;
      end
      DST_RD: begin
        raw_memrd = 1'b1; raw_mab = 3'd2; next_state = EXEC;
      end
      EXEC: begin
        if (is_jump) begin
          raw_rw = jump_taken; next_state = take_int ? INT_SP1 : FETCH;
        end else begin
          raw_ex = 1'b1; raw_rw = reg_write;
          if (is_push) begin
            next_state = PUSH_DEC;
          end else if (mem_write) begin
            next_state = DST_WR;
          end else begin
            next_state = take_int ? INT_SP1 : FETCH;
          end
        end
      end
      DST_WR: begin
        raw_memwr = 1'b1; raw_mab = is_fmt1 ? 3'd2 : 3'd1;
        next_state = take_int ? INT_SP1 : FETCH;
      end
      PUSH_DEC: begin
        raw_spf = 1'b1; next_state = PUSH_WR;
      end
      PUSH_WR: begin
        raw_memwr = 1'b1; raw_mab = 3'd3;
        next_state = take_int ? INT_SP1 : FETCH;
      end
      INT_SP1: begin
        raw_spf = 1'b1; next_state = INT_PC;
      end
      INT_PC: begin
        raw_memwr = 1'b1; raw_mab = 3'd3; raw_mdb = 2'd1; next_state = INT_SP2;
      end
      INT_SP2: begin
        raw_spf = 1'b1; next_state = INT_SR;
      end
      INT_SR: begin
        raw_memwr = 1'b1; raw_mab = 3'd3; raw_mdb = 2'd2; next_state = INT_VEC;
      end
      INT_VEC: begin
        raw_memrd = 1'b1; raw_intack = 1'b1; raw_mab = 3'd4; next_state = FETCH;
      end
      default: begin
        next_state = RST_VEC;
      end
    endcase
  end

  // Strobes are held quiet for the whole time reset is asserted
  always_comb begin
    State = state;
    if (rst) begin
      {IF, IdxF, SPF, INTACK, Ex, srcInc, RW} = 7'd0;
      {MemRd, MemWr, Illegal} = 3'd0;
      MabSel = 3'd0;
      MdbSel = 2'd0;
    end else begin
      {IF, IdxF, SPF, INTACK, Ex, srcInc, RW} =
        {raw_if, raw_idxf, raw_spf, raw_intack, raw_ex, raw_srcinc, raw_rw};
      {MemRd, MemWr, Illegal} = {raw_memrd, raw_memwr, raw_illegal};
      MabSel = raw_mab;
      MdbSel = raw_mdb;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a per-instruction cycle-list model predicts
// every output each cycle; literal state sequences pin the model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mdb, vec_addr;
  logic [3:0]  sr_flags;
  logic        gie, irq, nmi;
  logic [15:0] iw, vec_out;
  logic        sig_if, sig_idxf, sig_spf, sig_intack, sig_ex, sig_srcinc, sig_rw;
  logic        mem_rd, mem_wr, illegal;
  logic [2:0]  mab_sel;
  logic [1:0]  mdb_sel;
  logic [3:0]  state;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .MDB(mdb), .SRflags(sr_flags), .GIE(gie), .IRQ(irq),
    .NMI(nmi), .VecAddr(vec_addr), .IW(iw), .IF(sig_if), .IdxF(sig_idxf),
    .SPF(sig_spf), .INTACK(sig_intack), .Ex(sig_ex), .srcInc(sig_srcinc),
    .RW(sig_rw), .MemRd(mem_rd), .MemWr(mem_wr), .MabSel(mab_sel),
    .MdbSel(mdb_sel), .VecOut(vec_out), .Illegal(illegal), .State(state)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S_IF  = 7'b1000000;
  localparam logic [6:0] S_IDX = 7'b0100000;
  localparam logic [6:0] S_SPF = 7'b0010000;
  localparam logic [6:0] S_ACK = 7'b0001000;
  localparam logic [6:0] S_EX  = 7'b0000100;
  localparam logic [6:0] S_INC = 7'b0000010;
  localparam logic [6:0] S_RW  = 7'b0000001;
  localparam logic [50:0] RESET_VIEW =
    {4'd0, 7'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 16'hFFFE, 16'h0000};

  typedef struct packed {
    logic [15:0] mdb;
    logic [3:0]  flags;
    logic        gie, irq, nmi;
    logic [15:0] vaddr;
    logic [50:0] exp;
  } cyc_t;

  cyc_t        q[$];
  logic [3:0]  seen[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_iw, m_vec, c_vaddr;
  logic [3:0]  c_flags;
  logic        c_gie, c_irq, c_nmi;

  function automatic logic [50:0] act();
    return {state, sig_if, sig_idxf, sig_spf, sig_intack, sig_ex, sig_srcinc, sig_rw,
            mem_rd, mem_wr, mab_sel, mdb_sel, illegal, vec_out, iw};
  endfunction

  function automatic logic [50:0] mk(input logic [3:0] st, input logic [6:0] stb,
                                     input logic rd, input logic wr, input logic [2:0] mab,
                                     input logic [1:0] md, input logic ill);
    return {st, stb, rd, wr, mab, md, ill, m_vec, m_iw};
  endfunction

  task automatic push(input logic [15:0] d, input logic [50:0] e);
    cyc_t c;
    c.mdb = d; c.flags = c_flags; c.gie = c_gie; c.irq = c_irq; c.nmi = c_nmi;
    c.vaddr = c_vaddr; c.exp = e;
    q.push_back(c);
  endtask

  task automatic add_rstvec();
    m_iw = 16'h0000;
    m_vec = 16'hFFFE;
    push(16'hC000, mk(4'd0, S_ACK, 1'b1, 1'b0, 3'd4, 2'd0, 1'b0));
  endtask

  // One instruction: list its cycles from the addressing-mode cost rules.
  task automatic add_instr(input logic [15:0] w, input logic [15:0] w1, input logic [15:0] w2);
    logic jmp, f1, f2, is_push, mem_op, reg_dst, taken;
    logic [3:0] r;
    logic [1:0] as_m;
    jmp = (w[15:13] == 3'b001);
    f2 = (w[15:10] == 6'b000100) && (w[9:7] < 3'd5);
    f1 = (w[15:12] >= 4'd4);
    push(w, mk(4'd1, S_IF, 1'b1, 1'b0, 3'd0, 2'd0, !(jmp || f1 || f2)));
    m_iw = w;
    if (!(jmp || f1 || f2)) return;
    r = f1 ? w[11:8] : w[3:0];
    as_m = w[5:4];
    mem_op = 1'b0;
    if (jmp) begin
      case (w[12:10])
        3'd0: taken = !c_flags[1];
        3'd1: taken = c_flags[1];
        3'd2: taken = !c_flags[0];
        3'd3: taken = c_flags[0];
        3'd4: taken = c_flags[2];
        3'd5: taken = (c_flags[2] == c_flags[3]);
        3'd6: taken = (c_flags[2] != c_flags[3]);
        default: taken = 1'b1;
      endcase
      push(16'h0000, mk(4'd6, taken ? S_RW : 7'd0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
    end else begin
      if (as_m == 2'b01 && r != 4'd3) begin
        push(w1, mk(4'd2, S_IDX, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
        push(w2, mk(4'd3, 7'd0, 1'b1, 1'b0, 3'd1, 2'd0, 1'b0));
        mem_op = 1'b1;
      end else if (as_m[1] && r != 4'd2 && r != 4'd3) begin
        push(w1, mk(4'd3, as_m[0] ? S_INC : 7'd0, 1'b1, 1'b0, 3'd1, 2'd0, 1'b0));
        mem_op = 1'b1;
      end
      if (f1 && w[7]) begin
        push(w2, mk(4'd4, S_IDX, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
        push(16'h0000, mk(4'd5, 7'd0, 1'b1, 1'b0, 3'd2, 2'd0, 1'b0));
      end
      is_push = f2 && (w[9:7] == 3'd4);
      reg_dst = f1 ? (!w[7] && w[15:12] != 4'h9 && w[15:12] != 4'hB)
                   : (!is_push && as_m == 2'b00);
      push(16'h0000, mk(4'd6, S_EX | (reg_dst ? S_RW : 7'd0), 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
      if (is_push) begin
        push(16'h0000, mk(4'd8, S_SPF, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
        push(16'h0000, mk(4'd9, 7'd0, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0));
      end else if (f1 && w[7]) begin
        push(16'h0000, mk(4'd7, 7'd0, 1'b0, 1'b1, 3'd2, 2'd0, 1'b0));
      end else if (f2 && mem_op) begin
        push(16'h0000, mk(4'd7, 7'd0, 1'b0, 1'b1, 3'd1, 2'd0, 1'b0));
      end
    end
    if (c_nmi || (c_irq && c_gie)) begin
      m_vec = c_vaddr;
      push(16'h0000, mk(4'd10, S_SPF, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
      push(16'h0000, mk(4'd11, 7'd0, 1'b0, 1'b1, 3'd3, 2'd1, 1'b0));
      push(16'h0000, mk(4'd12, S_SPF, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
      push(16'h0000, mk(4'd13, 7'd0, 1'b0, 1'b1, 3'd3, 2'd2, 1'b0));
      push(16'h0000, mk(4'd14, S_ACK, 1'b1, 1'b0, 3'd4, 2'd0, 1'b0));
    end
  endtask

  // Drive each queued cycle after the rising edge and compare on the falling edge.
  task automatic run();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      mdb = c.mdb; sr_flags = c.flags; gie = c.gie; irq = c.irq; nmi = c.nmi;
      vec_addr = c.vaddr;
      @(negedge clk);
      n_checks++;
      seen.push_back(state);
      if (act() !== c.exp) begin
        n_fail++;
        $display("FAIL cycle t=%0t got=%h exp=%h", $time, act(), c.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_seq(input string nm, input int n, input logic [55:0] s);
    logic [55:0] a;
    a = '0;
    foreach (seen[i]) a = {a[51:0], seen[i]};
    n_checks++;
    if (seen.size() != n || a !== s) begin
      n_fail++;
      $display("FAIL seq_%s got=%h (%0d states) exp=%h (%0d states)", nm, a, seen.size(), s, n);
    end
    seen.delete();
  endtask

  initial begin
    rst = 1'b1; mdb = 16'h0; sr_flags = 4'h0; gie = 1'b0; irq = 1'b0; nmi = 1'b0;
    vec_addr = 16'h0;
    c_flags = 4'h0; c_gie = 1'b0; c_irq = 1'b0; c_nmi = 1'b0; c_vaddr = 16'h0;
    m_iw = 16'h0; m_vec = 16'hFFFE;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (act() !== RESET_VIEW) begin
        n_fail++;
        $display("FAIL reset got=%h exp=%h", act(), RESET_VIEW);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;

    add_rstvec(); add_instr(16'h4405, 16'h0, 16'h0); run();
    check_seq("rst_mov", 3, 56'h016);
    add_instr(16'h50B2, 16'h1234, 16'h0200); run();
    check_seq("add_imm_abs", 6, 56'h134567);
    add_instr(16'h9405, 16'h0, 16'h0); run();
    check_seq("cmp", 2, 56'h16);

    c_flags = 4'b0000; add_instr(16'h2402, 16'h0, 16'h0);
    c_flags = 4'b0010; add_instr(16'h2402, 16'h0, 16'h0);
    c_flags = 4'b1100; add_instr(16'h3400, 16'h0, 16'h0); add_instr(16'h3800, 16'h0, 16'h0);
    run();
    check_seq("jumps", 8, 56'h16161616);

    c_flags = 4'b0000;
    add_instr(16'h4415, 16'h0002, 16'h5555);
    add_instr(16'h1105, 16'h0, 16'h0);
    add_instr(16'h1205, 16'h0, 16'h0);
    add_instr(16'h1025, 16'hAAAA, 16'h0);
    run();
    check_seq("modes", 14, 56'h12361616891367);

    c_irq = 1'b1; c_gie = 1'b1; c_vaddr = 16'hFFF2;
    add_instr(16'h4405, 16'h0, 16'h0); run();
    check_seq("irq", 7, 56'h16ABCDE);
    c_gie = 1'b0;
    add_instr(16'h4405, 16'h0, 16'h0); run();
    check_seq("irq_masked", 2, 56'h16);
    c_nmi = 1'b1; c_vaddr = 16'hFFFC;
    add_instr(16'h4405, 16'h0, 16'h0); run();
    check_seq("nmi", 7, 56'h16ABCDE);
    c_irq = 1'b0; c_nmi = 1'b0;

    add_instr(16'h1284, 16'h0, 16'h0); add_instr(16'h0000, 16'h0, 16'h0);
    add_instr(16'h4405, 16'h0, 16'h0); run();
    check_seq("illegal", 4, 56'h1116);

    // Abort ADD to memory while it sits in DST_RD
    add_instr(16'h50B2, 16'h1234, 16'h0200);
    q = q[0:2];
    run();
    check_seq("abort_head", 3, 56'h134);
    @(negedge clk);
    n_checks++;
    if (state !== 4'd5) begin
      n_fail++;
      $display("FAIL abort_state got=%0d exp=5", state);
    end
    #1 rst = 1'b1;
    repeat (4) begin
      #1;
      n_checks++;
      if (act() !== RESET_VIEW) begin
        n_fail++;
        $display("FAIL abort_reset got=%h exp=%h", act(), RESET_VIEW);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    add_rstvec(); add_instr(16'h4405, 16'h0, 16'h0); run();
    check_seq("restart", 3, 56'h016);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
